// File: rtl/pipeline_ctl.sv
// Pipeline control for a 5-stage core: start-up sequencing, stall/flush
// steering, and a halt sequence that drains the pipe before stopping.
module pipeline_ctl #(
    parameter int COUNTERSIZE = 3,
    parameter int STAGEMAX    = 5,
    parameter int DRAINCYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic                   halt,
    output logic [COUNTERSIZE-1:0] stage,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic                   halted
);

    localparam int DW = (DRAINCYCLES > 1) ? $clog2(DRAINCYCLES) : 1;
    localparam logic [COUNTERSIZE-1:0] STAGE_SAT  = COUNTERSIZE'(STAGEMAX);
    localparam logic [DW-1:0]          DRAIN_LOAD = DW'(DRAINCYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNTERSIZE-1:0] stage_q, stage_d;
    logic [DW-1:0]          drain_q, drain_d;
    logic                   stall_eff;

    // The hazard unit's stall is meaningless until the pipe holds two instructions.
    assign stall_eff = stall && (stage_q > COUNTERSIZE'(1));
    assign stage     = stage_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        drain_d = drain_q;
        stage_d = (stage_q == STAGE_SAT) ? stage_q : stage_q + COUNTERSIZE'(1);
        unique case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (!branch_taken && !stall_eff && halt) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                // A taken branch here is older than the halt, so the halt was wrong-path.
                if (branch_taken) begin
                    state_d = RUN;
                    drain_d = '0;
                end else if (drain_q == '0) begin
                    state_d = HALTED;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        halted      = 1'b0;
        unique case (state_q)
            IDLE: ;
            RUN, DRAIN: begin
                if (branch_taken) begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (state_q == DRAIN || halt && !stall_eff) begin
                    ifid_write = 1'b1;
                    ifid_flush = 1'b1;
                end else if (stall_eff) begin
                    idex_flush = 1'b1;
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                end
            end
            HALTED: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pipeline_ctl.sv
// Directed bench for pipeline_ctl: start-up, stall gating, event priority,
// wrong-path halt, full halt and asynchronous reset out of HALTED.
module tb_pipeline_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall, branch_taken, halt;
    logic [2:0] stage;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, halted;

    int total = 0;
    int bad   = 0;

    pipeline_ctl dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branch_taken(branch_taken),
        .halt        (halt),
        .stage       (stage),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_flush (exmem_flush),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, halted}.
    task automatic check_outs(input string tag, input logic [5:0] exp);
        check({tag, ".outs"}, {26'd0, pc_write, ifid_write, ifid_flush, idex_flush,
                               exmem_flush, halted}, {26'd0, exp});
    endtask

    // Drive inputs mid-cycle, then settle before looking at the combinational outputs.
    task automatic step(input logic s, input logic b, input logic h);
        @(negedge clk);
        stall        = s;
        branch_taken = b;
        halt         = h;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.stage", 32'(stage), 32'd0);
        check_outs("rst", 6'b000000);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle.stage", 32'(stage), 32'd0);
        check_outs("idle", 6'b000000);

        // Stage 1: stall must be ignored.
        step(1, 0, 0);
        check("s1.stage", 32'(stage), 32'd1);
        check_outs("s1.early_stall", 6'b110000);

        step(0, 0, 0);
        check("s2.stage", 32'(stage), 32'd2);
        check_outs("s2.run", 6'b110000);

        // Stage 3: stall wins over halt.
        step(1, 0, 1);
        check("s3.stage", 32'(stage), 32'd3);
        check_outs("s3.stall", 6'b000100);

        step(0, 0, 0);
        check("s4.stage", 32'(stage), 32'd4);
        check_outs("s4.halt_ignored", 6'b110000);

        // Branch wins over everything.
        step(1, 1, 1);
        check("s5.stage", 32'(stage), 32'd5);
        check_outs("s5.all_events", 6'b111110);

        step(0, 0, 0);
        check("s5.sat", 32'(stage), 32'd5);
        check_outs("s5.still_run", 6'b110000);

        // Wrong-path halt: branch on the second DRAIN cycle.
        step(0, 0, 1);
        check_outs("wp.accept", 6'b011000);
        step(0, 0, 0);
        check_outs("wp.drain1", 6'b011000);
        step(0, 1, 0);
        check_outs("wp.drain2_branch", 6'b111110);
        step(0, 0, 0);
        check_outs("wp.back_run", 6'b110000);
        step(0, 0, 0);
        check_outs("wp.run2", 6'b110000);
        check("wp.stage", 32'(stage), 32'd5);

        // Real halt: acceptance cycle, then DRAINCYCLES drain cycles ignoring stall/halt.
        step(0, 0, 1);
        check_outs("h.accept", 6'b011000);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1);
            check_outs($sformatf("h.drain%0d", i), 6'b011000);
        end
        for (int i = 0; i < 22; i++) begin
            step(i[0], i[1], i[2]);
            check_outs($sformatf("h.halted%0d", i), 6'b000001);
        end

        // Asynchronous reset between edges.
        step(0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("ar.halted", 32'(halted), 32'd0);
        check("ar.stage", 32'(stage), 32'd0);
        check_outs("ar", 6'b000000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ar.idle_stage", 32'(stage), 32'd0);
        check_outs("ar.idle", 6'b000000);
        step(0, 0, 0);
        check("ar.restart_stage", 32'(stage), 32'd1);
        check_outs("ar.restart", 6'b110000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctl.md
PIPELINE_CTL -- requirements
Module: pipeline_ctl

Interface
REQ-001 SHALL have parameter COUNTERSIZE, default 3, width of the stage counter (matches bus.vh).
REQ-002 SHALL have parameter STAGEMAX, default 5, saturation value of the stage counter (pipeline depth).
REQ-003 SHALL have parameter DRAINCYCLES, default 4, cycles spent draining after an accepted halt.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports named as below.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port stall  input  1  load-use stall request from the hazard unit.
REQ-008 SHALL have port branch_taken  input  1  branch resolved taken in MEM; PC target valid this cycle.
REQ-009 SHALL have port halt  input  1  halt instruction present in ID.
REQ-010 SHALL have port stage  output  COUNTERSIZE  cycles since reset, saturating; feeds hazard unit.
REQ-011 SHALL have port pc_write  output  1  PC register load enable.
REQ-012 SHALL have port ifid_write  output  1  IF/ID register load enable.
REQ-013 SHALL have port ifid_flush  output  1  IF/ID loads NOP.
REQ-014 SHALL have port idex_flush  output  1  ID/EX loads NOP (bubble or flush).
REQ-015 SHALL have port exmem_flush  output  1  EX/MEM loads NOP.
REQ-016 SHALL have port halted  output  1  pipeline stopped and empty.

Function
REQ-017 SHALL implement the states IDLE, RUN, DRAIN and HALTED.
REQ-018 SHALL leave IDLE for RUN unconditionally after 1 cycle, with all enables and flushes 0 during IDLE.
REQ-019 SHALL increment stage by 1 on every clock edge after reset until it equals STAGEMAX, then hold it, independent of state.
REQ-020 SHALL define stall_eff = stall AND (stage > 1); stall SHALL be ignored when stage <= 1.
REQ-021 SHALL apply RUN priority branch_taken > stall_eff > halt > normal flow.
REQ-022 SHALL, in RUN with no event: pc_write=1, ifid_write=1, all flushes 0.
REQ-023 SHALL, in RUN on branch_taken: pc_write=1, ifid_write=1, ifid_flush=idex_flush=exmem_flush=1 in the same cycle (combinational); the state SHALL remain RUN; stall and halt SHALL be ignored that cycle.
REQ-024 SHALL, in RUN on stall_eff without branch_taken: pc_write=0, ifid_write=0, idex_flush=1, other flushes 0; halt SHALL be ignored that cycle and re-sampled on the next one.
REQ-025 SHALL, in RUN on halt without branch_taken or stall_eff: pc_write=0, ifid_write=1, ifid_flush=1, move to DRAIN, and load the drain counter with DRAINCYCLES-1.
REQ-026 SHALL, in DRAIN: pc_write=0, ifid_write=1, ifid_flush=1, decrement the drain counter each cycle, and move to HALTED when the counter is 0.
REQ-027 SHALL, on branch_taken in DRAIN (an older branch, so the halt was wrong-path), apply REQ-023 outputs and return to RUN, clearing the drain counter.
REQ-028 SHALL ignore stall and halt while in DRAIN.
REQ-029 SHALL, in HALTED: all enables 0, all flushes 0, halted=1, and ignore all inputs; the only exit SHALL be reset.
REQ-030 SHALL drive halted=1 only in HALTED.
REQ-031 SHALL drive all outputs other than stage combinationally from state, the counters and the inputs; there SHALL be no combinational path from any input to stage.

Reset
REQ-032 SHALL, while rst=1, asynchronously force state=IDLE, stage=0, drain counter=0, all enables 0, all flushes 0, halted=0.
REQ-033 SHALL, on reset asserted mid-DRAIN or in HALTED, take effect immediately and restart the sequence from IDLE.

Verification
REQ-034 SHALL verify start-up: release rst, no inputs -> stage reads 0,1,2,3,4,5,5 over successive edges; pc_write 0 in cycle 0, then 1.
REQ-035 SHALL verify early stall: stall=1 at stage=1 -> pc_write=1, idex_flush=0; stall=1 at stage=3 -> pc_write=0, ifid_write=0, idex_flush=1.
REQ-036 SHALL verify simultaneous events: stall=1, halt=1 and branch_taken=1 in RUN -> all three flushes 1, pc_write=1, state RUN.
REQ-037 SHALL verify halt: halt=1 for 1 cycle in RUN -> pc_write=0, ifid_flush=1 for 4 cycles, then halted=1 held for 20+ cycles with all enables 0.
REQ-038 SHALL verify wrong-path halt: halt accepted, then branch_taken=1 on the 2nd DRAIN cycle -> flushes all 1 that cycle, RUN next cycle, halted never 1.
REQ-039 SHALL verify async reset: rst pulsed between clock edges while HALTED -> halted=0 and stage=0 before the next edge.
